// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 3;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, borrow out when the result goes negative.
// Latency: combinational, zero cycles.
// Backpressure: none, pure logic.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = (A - B) mod 2^WIDTH, Bout = (A < B).
// Latency: WIDTH edges from the accepting edge to Out_Valid high.
// Backpressure: result is held in DONE until Out_Ready; one operand pair is in flight at a time.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             bin;
    logic [IW-1:0]    idx;
    logic             fs_diff;
    logic             fs_bout;

    full_subtractor u_fs (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Bin  (bin),
        .Diff (fs_diff),
        .Bout (fs_bout)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = (res_sr >> 1) | (WIDTH'(fs_diff) << (WIDTH - 1));

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state     <= IDLE;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sr    <= '0;
            bin       <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid && In_Ready) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        bin      <= 1'b0;
                        idx      <= '0;
                        state    <= RUN;
                        In_Ready <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    bin    <= fs_bout;
                    res_sr <= res_next;
                    idx    <= idx + IW'(1);
                    // Publish only on the final bit so Diff/Bout keep the previous result during RUN.
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        Out_Valid <= 1'b1;
                        Diff      <= res_next;
                        Bout      <= fs_bout;
                    end
                end
                DONE: begin
                    if (Out_Ready) begin
                        state     <= IDLE;
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    Out_Valid <= 1'b0;
                    In_Ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=3) against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 3;

    logic         Clk = 1'b0;
    logic         RstN;
    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [W-1:0] Diff;
    logic         Bout;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Diff      (Diff),
        .Bout      (Bout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_diff(input int a, input int b);
        return W'((a - b + (1 << W)) % (1 << W));
    endfunction

    function automatic logic ref_bout(input int a, input int b);
        return (a < b);
    endfunction

    // One full transaction; junk drives a different pair with In_Valid high while busy.
    task automatic run_op(input int a, input int b, input int hold, input bit junk);
        int k;
        logic [W-1:0] ed;
        logic         eb;
        ed = ref_diff(a, b);
        eb = ref_bout(a, b);
        k = 0;
        while (!In_Ready && k < 20) begin
            @(posedge Clk); #1; k++;
        end
        chk("in_ready_idle", In_Ready, 1);
        In_Valid = 1'b1; A = W'(a); B = W'(b);
        @(posedge Clk); #1;
        if (junk) begin
            A = '0; B = '1;
        end else begin
            In_Valid = 1'b0;
        end
        k = 0;
        while (!Out_Valid && k < 20) begin
            if (k == 0) begin
                chk("hold_diff_run", Diff, last_diff);
                chk("hold_bout_run", Bout, last_bout);
                chk("in_ready_run", In_Ready, 0);
            end
            @(posedge Clk); #1; k++;
        end
        chk("latency", k, W);
        chk("diff", Diff, ed);
        chk("bout", Bout, eb);
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            chk("stall_valid", Out_Valid, 1);
            chk("stall_diff", Diff, ed);
            chk("stall_bout", Bout, eb);
            chk("stall_in_ready", In_Ready, 0);
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        chk("post_hs_valid", Out_Valid, 0);
        chk("post_hs_in_ready", In_Ready, 1);
        chk("post_hs_diff", Diff, ed);
        last_diff = ed;
        last_bout = eb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] q_a[$];
        logic [W-1:0] q_b[$];
        int sent, got, cyc, last_cyc;
        logic [W-1:0] ea, eb;

        RstN = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; A = '0; B = '0;
        #12;
        chk("rst_in_ready", In_Ready, 1);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_bout", Bout, 0);
        @(negedge Clk);
        RstN = 1'b1;

        run_op(5, 3, 0, 1'b0);
        run_op(3, 5, 4, 1'b0);
        run_op(0, 1, 0, 1'b0);
        run_op(7, 7, 1, 1'b0);
        run_op(6, 2, 2, 1'b1);

        // Abort mid-RUN with an asynchronous reset.
        In_Valid = 1'b1; A = 3'd2; B = 3'd5;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        @(posedge Clk); #2;
        RstN = 1'b0;
        #1;
        chk("abort_in_ready", In_Ready, 1);
        chk("abort_out_valid", Out_Valid, 0);
        chk("abort_diff", Diff, 0);
        chk("abort_bout", Bout, 0);
        @(posedge Clk); #3;
        RstN = 1'b1;
        last_diff = '0;
        last_bout = 1'b0;
        run_op(4, 1, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            run_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Exhaustive back-to-back with In_Valid and Out_Ready tied high.
        sent = 0; got = 0; cyc = 0; last_cyc = -1;
        Out_Ready = 1'b1; In_Valid = 1'b1;
        while (got < 64 && cyc < 1000) begin
            if (Out_Valid) begin
                if (q_a.size() == 0) begin
                    chk("b2b_spurious", 1, 0);
                end else begin
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    chk("b2b_diff", Diff, ref_diff(int'(ea), int'(eb)));
                    chk("b2b_bout", Bout, ref_bout(int'(ea), int'(eb)));
                    if (last_cyc >= 0) chk("b2b_gap", cyc - last_cyc, W + 2);
                    last_cyc = cyc;
                    got++;
                end
            end
            if (In_Ready) begin
                if (sent < 64) begin
                    A = W'(sent / 8);
                    B = W'(sent % 8);
                    q_a.push_back(A);
                    q_b.push_back(B);
                    sent++;
                end else begin
                    In_Valid = 1'b0;
                end
            end
            @(posedge Clk); #1;
            cyc++;
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        chk("b2b_count", got, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
